alu_op_issuer: RTL and testbench

ALU_OP_ISSUER -- requirements
Module: alu_op_issuer

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_cmd_fifo.sv | 61 ++++++
 rtl/alu_op_issuer.sv | 203 ++++++++++++++++++++
 tb/tb_alu_op_issuer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_pkg : shared types and constants for the ALU command issuer  |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Bit positions inside m_flags = {OFLOW, COUT, G, L, E}
    localparam int C_FLAG_E     = 0;
    localparam int C_FLAG_L     = 1;
    localparam int C_FLAG_G     = 2;
    localparam int C_FLAG_COUT  = 3;
    localparam int C_FLAG_OFLOW = 4;
    localparam int C_FLAG_W     = 5;

    localparam logic [3:0] C_CMD_MUL_INC = 4'd9;
    localparam logic [3:0] C_CMD_MUL_SHL = 4'd10;

    // Arithmetic-mode multiplies need one extra result cycle
    function automatic logic lat_is_long(input logic mode, input logic [3:0] cmd);
        return mode && ((cmd == C_CMD_MUL_INC) || (cmd == C_CMD_MUL_SHL));
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_cmd_fifo : power-of-two command queue, push/pop same edge OK |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module alu_cmd_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int C_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [C_AW-1:0]  r_wr_ptr;
    logic [C_AW-1:0]  r_rd_ptr;
    logic [C_AW:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // A full queue refuses the push even when a pop frees a slot this edge
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    assign full  = (r_count == (C_AW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign rdata = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_op_issuer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_op_issuer : queues host commands and issues them one at a    |
// | time to the ALU. Optional macro ALU_ISSUE_STATS_EN adds counters.|
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
module alu_op_issuer
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_opa,
    input  logic [DATA_WIDTH-1:0] s_opb,
    input  logic [1:0]            s_inp_valid,
    input  logic [3:0]            s_cmd,
    input  logic                  s_mode,
    input  logic                  s_cin,
    output logic                  CE,
    output logic                  MODE,
    output logic [DATA_WIDTH-1:0] OPA,
    output logic [DATA_WIDTH-1:0] OPB,
    output logic [1:0]            INP_VALID,
    output logic [3:0]            CMD,
    output logic                  CIN,
    input  logic [DATA_WIDTH+1:0] RES,
    input  logic                  ERR,
    input  logic                  OFLOW,
    input  logic                  COUT,
    input  logic                  G,
    input  logic                  L,
    input  logic                  E,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH+1:0] m_res,
    output logic                  m_err,
    output logic [4:0]            m_flags
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [15:0]           issued_cnt,
    output logic [15:0]           err_cnt
`endif
);
    localparam int C_CMD_W = 2*DATA_WIDTH + 8;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      r_rst_done;
    logic                      r_lat;
    logic [C_CMD_W-1:0]        w_push_data;
    logic [C_CMD_W-1:0]        w_head;
    logic                      w_full;
    logic                      w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_q_count_unused;
    logic                      w_pop;
    logic                      w_capture;
    logic                      w_lat_load;
    logic                      w_lat_dec;
    logic                      w_mvalid_clr;
    logic [C_FLAG_W-1:0]       w_flags;

    assign s_ready     = r_rst_done && !w_full;
    assign w_push_data = {s_mode, s_cin, s_cmd, s_inp_valid, s_opa, s_opb};

    alu_cmd_fifo #(
        .WIDTH (C_CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s_valid && s_ready),
        .wdata (w_push_data),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_q_count_unused)
    );

    always_comb begin
        w_flags               = '0;
        w_flags[C_FLAG_E]     = E;
        w_flags[C_FLAG_L]     = L;
        w_flags[C_FLAG_G]     = G;
        w_flags[C_FLAG_COUT]  = COUT;
        w_flags[C_FLAG_OFLOW] = OFLOW;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rst_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rst_done <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        w_lat_load   = 1'b0;
        w_lat_dec    = 1'b0;
        w_mvalid_clr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                w_lat_load  = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (!r_lat) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_lat_dec   = 1'b1;
                end
            end
            ST_HOLD: begin
                // Accepted result frees the ALU; issue the next command on the same edge
                if (m_ready) begin
                    w_mvalid_clr = 1'b1;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_DRIVE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            CE        <= 1'b0;
            MODE      <= 1'b0;
            OPA       <= '0;
            OPB       <= '0;
            INP_VALID <= 2'b00;
            CMD       <= 4'd0;
            CIN       <= 1'b0;
            r_lat     <= 1'b0;
            m_valid   <= 1'b0;
            m_res     <= '0;
            m_err     <= 1'b0;
            m_flags   <= '0;
        end else begin
            if (w_pop) begin
                CE        <= 1'b1;
                MODE      <= w_head[C_CMD_W-1];
                CIN       <= w_head[C_CMD_W-2];
                CMD       <= w_head[C_CMD_W-3 -: 4];
                INP_VALID <= w_head[2*DATA_WIDTH+1 -: 2];
                OPA       <= w_head[2*DATA_WIDTH-1 -: DATA_WIDTH];
                OPB       <= w_head[DATA_WIDTH-1:0];
            end
            if (w_lat_load) begin
                r_lat <= lat_is_long(MODE, CMD);
            end else if (w_lat_dec) begin
                r_lat <= 1'b0;
            end
            if (w_capture) begin
                CE        <= 1'b0;
                INP_VALID <= 2'b00;
                m_valid   <= 1'b1;
                m_res     <= RES;
                m_err     <= ERR;
                m_flags   <= w_flags;
            end else if (w_mvalid_clr) begin
                m_valid   <= 1'b0;
            end
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued_cnt <= 16'd0;
            err_cnt    <= 16'd0;
        end else if (w_capture) begin
            if (issued_cnt != 16'hFFFF) issued_cnt <= issued_cnt + 16'd1;
            if (ERR && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_op_issuer.sv
`default_nettype none
// Directed self-checking bench for alu_op_issuer with a combinational ALU stub.
module tb_alu_op_issuer;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_opa;
    logic [DW-1:0] s_opb;
    logic [1:0]    s_inp_valid;
    logic [3:0]    s_cmd;
    logic          s_mode;
    logic          s_cin;
    logic          CE;
    logic          MODE;
    logic [DW-1:0] OPA;
    logic [DW-1:0] OPB;
    logic [1:0]    INP_VALID;
    logic [3:0]    CMD;
    logic          CIN;
    logic [DW+1:0] RES;
    logic          ERR;
    logic          OFLOW;
    logic          COUT;
    logic          G;
    logic          L;
    logic          E;
    logic          m_valid;
    logic          m_ready;
    logic [DW+1:0] m_res;
    logic          m_err;
    logic [4:0]    m_flags;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0]   issued_cnt;
    logic [15:0]   err_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_op_issuer #(.DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_opa(s_opa), .s_opb(s_opb),
        .s_inp_valid(s_inp_valid), .s_cmd(s_cmd), .s_mode(s_mode), .s_cin(s_cin),
        .CE(CE), .MODE(MODE), .OPA(OPA), .OPB(OPB), .INP_VALID(INP_VALID),
        .CMD(CMD), .CIN(CIN),
        .RES(RES), .ERR(ERR), .OFLOW(OFLOW), .COUT(COUT), .G(G), .L(L), .E(E),
        .m_valid(m_valid), .m_ready(m_ready), .m_res(m_res), .m_err(m_err),
        .m_flags(m_flags)
`ifdef ALU_ISSUE_STATS_EN
        , .issued_cnt(issued_cnt), .err_cnt(err_cnt)
`endif
    );

    // ALU stub: add, increment-multiply (9), shift-multiply (10); logic mode ANDs,
    // and CMD 12 with any of OPB[7:4] set is an error.
    always_comb begin
        RES = '0;
        ERR = 1'b0;
        if (MODE) begin
            case (CMD)
                4'd9:    RES = ({2'b00, OPA} + 10'd1) * ({2'b00, OPB} + 10'd1);
                4'd10:   RES = {1'b0, OPA, 1'b0} * {2'b00, OPB};
                default: RES = {2'b00, OPA} + {2'b00, OPB};
            endcase
        end else if (CMD == 4'd12 && (|OPB[7:4])) begin
            ERR = 1'b1;
        end else begin
            RES = {2'b00, OPA & OPB};
        end
        G     = OPA > OPB;
        L     = OPA < OPB;
        E     = OPA == OPB;
        COUT  = RES[8];
        OFLOW = RES[9];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic mode, input logic [3:0] cmd, input logic [7:0] a,
                            input logic [7:0] b, input logic [1:0] iv);
        s_valid = 1'b1; s_mode = mode; s_cmd = cmd; s_opa = a; s_opb = b;
        s_inp_valid = iv; s_cin = 1'b0;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        if (s_ready !== 1'b0) begin $display("FAIL rst_s_ready got=%b exp=0", s_ready); bad++; end total++;
        if (CE !== 1'b0) begin $display("FAIL rst_ce got=%b exp=0", CE); bad++; end total++;
        if (m_valid !== 1'b0) begin $display("FAIL rst_m_valid got=%b exp=0", m_valid); bad++; end total++;
        if (INP_VALID !== 2'b00) begin $display("FAIL rst_inp_valid got=%b exp=00", INP_VALID); bad++; end total++;
        if ({OPA, OPB, CMD, MODE, CIN} !== 23'd0) begin $display("FAIL rst_alu_regs got=%h exp=0", {OPA, OPB, CMD, MODE, CIN}); bad++; end total++;
        if ({m_res, m_err, m_flags} !== 16'd0) begin $display("FAIL rst_m_regs got=%h exp=0", {m_res, m_err, m_flags}); bad++; end total++;
        rst = 1'b0;
        #1;
        if (s_ready !== 1'b0) begin $display("FAIL rel_s_ready_early got=%b exp=0", s_ready); bad++; end total++;
        tick();
        if (s_ready !== 1'b1) begin $display("FAIL rel_s_ready got=%b exp=1", s_ready); bad++; end total++;
    endtask

    task automatic test_err();
        push_cmd(1'b0, 4'd12, 8'h55, 8'h10, 2'b10);
        tick();
        if (CE !== 1'b1) begin $display("FAIL err_ce got=%b exp=1", CE); bad++; end total++;
        if (INP_VALID !== 2'b10) begin $display("FAIL err_inp_valid got=%b exp=10", INP_VALID); bad++; end total++;
        tick(); tick();
        if (m_valid !== 1'b1) begin $display("FAIL err_m_valid got=%b exp=1", m_valid); bad++; end total++;
        if (m_err !== 1'b1) begin $display("FAIL err_m_err got=%b exp=1", m_err); bad++; end total++;
        if (m_flags !== 5'b00100) begin $display("FAIL err_flags got=%b exp=00100", m_flags); bad++; end total++;
`ifdef ALU_ISSUE_STATS_EN
        if (issued_cnt !== 16'd1) begin $display("FAIL err_issued_cnt got=%0d exp=1", issued_cnt); bad++; end total++;
        if (err_cnt !== 16'd1) begin $display("FAIL err_err_cnt got=%0d exp=1", err_cnt); bad++; end total++;
`endif
        m_ready = 1'b1; tick(); m_ready = 1'b0;
        if (m_valid !== 1'b0) begin $display("FAIL err_m_valid_clr got=%b exp=0", m_valid); bad++; end total++;
    endtask

    task automatic test_add_latency();
        push_cmd(1'b1, 4'd0, 8'h0F, 8'h01, 2'b11);
        tick();
        if (CE !== 1'b1) begin $display("FAIL add_ce1 got=%b exp=1", CE); bad++; end total++;
        if ({OPA, OPB, INP_VALID} !== {8'h0F, 8'h01, 2'b11}) begin $display("FAIL add_alu_in got=%h exp=%h", {OPA, OPB, INP_VALID}, {8'h0F, 8'h01, 2'b11}); bad++; end total++;
        tick();
        if (m_valid !== 1'b0) begin $display("FAIL add_m_valid_early got=%b exp=0", m_valid); bad++; end total++;
        tick();
        if (m_valid !== 1'b1) begin $display("FAIL add_m_valid got=%b exp=1", m_valid); bad++; end total++;
        if (m_res !== 10'h010) begin $display("FAIL add_m_res got=%h exp=010", m_res); bad++; end total++;
        if (m_err !== 1'b0) begin $display("FAIL add_m_err got=%b exp=0", m_err); bad++; end total++;
        if (m_flags !== 5'b00100) begin $display("FAIL add_flags got=%b exp=00100", m_flags); bad++; end total++;
        if ({CE, INP_VALID} !== 3'b000) begin $display("FAIL add_ce_off got=%b exp=000", {CE, INP_VALID}); bad++; end total++;
        m_ready = 1'b1; tick(); m_ready = 1'b0;
    endtask

    task automatic test_mul_latency();
        push_cmd(1'b1, 4'd9, 8'h03, 8'h04, 2'b11);
        tick();
        if (CE !== 1'b1) begin $display("FAIL mul_ce1 got=%b exp=1", CE); bad++; end total++;
        tick(); tick();
        if (CE !== 1'b1) begin $display("FAIL mul_ce3 got=%b exp=1", CE); bad++; end total++;
        if (m_valid !== 1'b0) begin $display("FAIL mul_m_valid_early got=%b exp=0", m_valid); bad++; end total++;
        tick();
        if (m_valid !== 1'b1) begin $display("FAIL mul_m_valid got=%b exp=1", m_valid); bad++; end total++;
        if (m_res !== 10'h014) begin $display("FAIL mul_m_res got=%h exp=014", m_res); bad++; end total++;
        if (m_flags !== 5'b00010) begin $display("FAIL mul_flags got=%b exp=00010", m_flags); bad++; end total++;
        if (CE !== 1'b0) begin $display("FAIL mul_ce_off got=%b exp=0", CE); bad++; end total++;
        m_ready = 1'b1; tick(); m_ready = 1'b0;
    endtask

    task automatic test_hold();
        push_cmd(1'b1, 4'd0, 8'h20, 8'h20, 2'b01);
        tick();
        if (INP_VALID !== 2'b01) begin $display("FAIL hold_inp_valid_fwd got=%b exp=01", INP_VALID); bad++; end total++;
        tick(); tick();
        for (int i = 0; i < 8; i++) begin
            if ({m_valid, m_res, m_err, m_flags} !== {1'b1, 10'h040, 1'b0, 5'b00001}) begin
                $display("FAIL hold_stable cyc=%0d got=%h exp=%h", i, {m_valid, m_res, m_err, m_flags}, {1'b1, 10'h040, 1'b0, 5'b00001}); bad++;
            end
            total++;
            if ({CE, INP_VALID} !== 3'b000) begin $display("FAIL hold_ce_off cyc=%0d got=%b exp=000", i, {CE, INP_VALID}); bad++; end total++;
            tick();
        end
        m_ready = 1'b1; tick(); m_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp_res;
        int n_seen;
        int last_cyc;
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (s_ready !== 1'b1) begin $display("FAIL b2b_ready_push%0d got=%b exp=1", i, s_ready); bad++; end total++;
            push_cmd(1'b1, 4'd0, 8'(i*16 + 1), 8'h01, 2'b11);
        end
        if (s_ready !== 1'b0) begin $display("FAIL b2b_full got=%b exp=0", s_ready); bad++; end total++;
        m_ready  = 1'b1;
        n_seen   = 0;
        last_cyc = 0;
        for (int c = 0; c < 40; c++) begin
            if (m_valid === 1'b1) begin
                exp_res = 10'(n_seen*16 + 2);
                if (m_res !== exp_res) begin $display("FAIL b2b_order idx=%0d got=%h exp=%h", n_seen, m_res, exp_res); bad++; end total++;
                if (n_seen > 0 && (c - last_cyc) != 3) begin $display("FAIL b2b_gap idx=%0d got=%0d exp=3", n_seen, c - last_cyc); bad++; end
                if (n_seen > 0) total++;
                last_cyc = c;
                n_seen++;
            end
            tick();
        end
        if (n_seen != 5) begin $display("FAIL b2b_count got=%0d exp=5", n_seen); bad++; end total++;
        m_ready = 1'b0;
    endtask

    task automatic test_rst_mid();
        m_ready = 1'b0;
        push_cmd(1'b1, 4'd9, 8'h02, 8'h02, 2'b11);
        push_cmd(1'b1, 4'd0, 8'h11, 8'h01, 2'b11);
        push_cmd(1'b1, 4'd0, 8'h22, 8'h01, 2'b11);
        if (CE !== 1'b1) begin $display("FAIL rmid_in_wait_ce got=%b exp=1", CE); bad++; end total++;
        rst = 1'b1;
        #1;
        if ({CE, m_valid, s_ready} !== 3'b000) begin $display("FAIL rmid_async got=%b exp=000", {CE, m_valid, s_ready}); bad++; end total++;
        tick(); tick();
        rst = 1'b0;
        tick();
        if (s_ready !== 1'b1) begin $display("FAIL rmid_s_ready got=%b exp=1", s_ready); bad++; end total++;
        for (int i = 0; i < 10; i++) begin
            if ({m_valid, CE} !== 2'b00) begin $display("FAIL rmid_quiet cyc=%0d got=%b exp=00", i, {m_valid, CE}); bad++; end total++;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_opa = '0; s_opb = '0; s_inp_valid = 2'b00;
        s_cmd = 4'd0; s_mode = 1'b0; s_cin = 1'b0; m_ready = 1'b0;
        test_reset();
        test_err();
        test_add_latency();
        test_mul_latency();
        test_hold();
        test_back_to_back();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
